// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared opcode, FSM state, ALU opcode and instruction-field
//            definitions for the ALU operation sequencer.
// Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // Instruction word layout: [8:6] opcode, [5:3] rd/ra, [2:0] rb
  localparam int C_INSTR_W = 9;
  localparam int C_OPC_W   = 3;
  localparam int C_FLD_W   = 3;

  // Sequencer instruction opcodes
  typedef enum logic [2:0] {
    OPC_ADD  = 3'b000,
    OPC_SHR  = 3'b001,
    OPC_SHL  = 3'b010,
    OPC_XOR  = 3'b011,
    OPC_CMP  = 3'b100,
    OPC_BZ   = 3'b101,
    OPC_BS   = 3'b110,
    OPC_HALT = 3'b111
  } opcode_e;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_BRANCH = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // ALU opcode values as understood by the datapath ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;

  // Branch condition selector
  localparam logic BR_ZERO = 1'b0;
  localparam logic BR_SIGN = 1'b1;

  // Instruction field extraction
  function automatic logic [C_OPC_W-1:0] instr_opc(input logic [C_INSTR_W-1:0] ins);
    return ins[8:6];
  endfunction

  function automatic logic [C_FLD_W-1:0] instr_ra(input logic [C_INSTR_W-1:0] ins);
    return ins[5:3];
  endfunction

  function automatic logic [C_FLD_W-1:0] instr_rb(input logic [C_INSTR_W-1:0] ins);
    return ins[2:0];
  endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_decode
// Purpose  : Combinational opcode decoder. Maps a sequencer opcode to the
//            ALU opcode and the control attributes used by the FSM.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  opcode_e    i_opcode,
  output logic [2:0] o_alu_op,
  output logic       o_writes_rd,
  output logic       o_sets_flags,
  output logic       o_is_branch,
  output logic       o_branch_cond,
  output logic       o_is_halt
);

  // Opcode to control attribute mapping; CMP reuses the ALU adder
  always_comb begin
    o_alu_op      = ALU_ADD;
    o_writes_rd   = 1'b0;
    o_sets_flags  = 1'b0;
    o_is_branch   = 1'b0;
    o_branch_cond = BR_ZERO;
    o_is_halt     = 1'b0;
    case (i_opcode)
      OPC_ADD: begin
        o_alu_op     = ALU_ADD;
        o_writes_rd  = 1'b1;
        o_sets_flags = 1'b1;
      end
      OPC_SHR: begin
        o_alu_op     = ALU_SHR;
        o_writes_rd  = 1'b1;
        o_sets_flags = 1'b1;
      end
      OPC_SHL: begin
        o_alu_op     = ALU_SHL;
        o_writes_rd  = 1'b1;
        o_sets_flags = 1'b1;
      end
      OPC_XOR: begin
        o_alu_op     = ALU_XOR;
        o_writes_rd  = 1'b1;
        o_sets_flags = 1'b1;
      end
      OPC_CMP: begin
        o_alu_op     = ALU_ADD;
        o_sets_flags = 1'b1;
      end
      OPC_BZ: begin
        o_is_branch   = 1'b1;
        o_branch_cond = BR_ZERO;
      end
      OPC_BS: begin
        o_is_branch   = 1'b1;
        o_branch_cond = BR_SIGN;
      end
      OPC_HALT: begin
        o_is_halt = 1'b1;
      end
      default: begin
        o_alu_op = ALU_ADD;
      end
    endcase
  end

endmodule : alu_seq_decode
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Control-side sequencer for the 8-bit ALU. Accepts one 9-bit
//            instruction at a time over valid/ready, reads operands from the
//            register file, drives the ALU, writes results back, keeps the
//            Zero/Sign flags and resolves flag-conditional branches.
// Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int OPS = 3,
  parameter int RA  = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_instr_valid,
  output logic           o_instr_ready,
  input  logic [8:0]     i_instr,
  output logic [RA-1:0]  o_rf_addr_a,
  output logic [RA-1:0]  o_rf_addr_b,
  input  logic [W-1:0]   i_rf_data_a,
  input  logic [W-1:0]   i_rf_data_b,
  output logic [OPS-1:0] o_alu_op,
  output logic [W-1:0]   o_alu_a,
  output logic [W-1:0]   o_alu_b,
  input  logic [W-1:0]   i_alu_out,
  input  logic           i_alu_zero,
  input  logic           i_alu_sign,
  output logic           o_rf_wr_en,
  output logic [RA-1:0]  o_rf_wr_addr,
  output logic [W-1:0]   o_rf_wr_data,
  output logic           o_flag_zero,
  output logic           o_flag_sign,
  output logic           o_br_valid,
  output logic           o_br_taken,
  output logic           o_halted
);

  state_t         r_state;
  state_t         w_state_nxt;
  opcode_e        r_opcode;
  logic [RA-1:0]  r_rf_addr_a;
  logic [RA-1:0]  r_rf_addr_b;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [W-1:0]   r_result;
  logic           r_flag_zero;
  logic           r_flag_sign;

  logic [2:0]     w_alu_op;
  logic           w_writes_rd;
  logic           w_sets_flags;
  logic           w_is_branch;
  logic           w_branch_cond;
  logic           w_is_halt;
  logic           w_accept;
  logic           w_in_exec;

  alu_seq_decode u_decode (
    .i_opcode      (r_opcode),
    .o_alu_op      (w_alu_op),
    .o_writes_rd   (w_writes_rd),
    .o_sets_flags  (w_sets_flags),
    .o_is_branch   (w_is_branch),
    .o_branch_cond (w_branch_cond),
    .o_is_halt     (w_is_halt)
  );

  assign w_accept  = (r_state == ST_IDLE) && i_instr_valid;
  assign w_in_exec = (r_state == ST_EXEC);

  // Next-state selection; one instruction in flight, HALT is terminal
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_instr_valid) begin
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_is_branch) begin
          w_state_nxt = ST_BRANCH;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = w_writes_rd ? ST_WB : ST_IDLE;
      end
      ST_WB:     w_state_nxt = ST_IDLE;
      ST_BRANCH: w_state_nxt = ST_IDLE;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, instruction capture, operand latch, result and flag capture.
  // The register addresses are latched at the handshake so they appear
  // during DECODE and then hold until the next accepted instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_opcode    <= OPC_ADD;
      r_rf_addr_a <= '0;
      r_rf_addr_b <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_result    <= '0;
      r_flag_zero <= 1'b0;
      r_flag_sign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opcode    <= opcode_e'(instr_opc(i_instr));
        r_rf_addr_a <= RA'(instr_ra(i_instr));
        r_rf_addr_b <= RA'(instr_rb(i_instr));
      end
      if (r_state == ST_DECODE) begin
        r_op_a <= i_rf_data_a;
        r_op_b <= i_rf_data_b;
      end
      if (w_in_exec) begin
        r_result <= i_alu_out;
        if (w_sets_flags) begin
          r_flag_zero <= i_alu_zero;
          r_flag_sign <= i_alu_sign;
        end
      end
    end
  end

  // Output drive: ALU and write-back buses are forced to zero outside
  // their owning state so downstream logic never sees stale operands.
  always_comb begin
    o_instr_ready = (r_state == ST_IDLE);
    o_rf_addr_a   = r_rf_addr_a;
    o_rf_addr_b   = r_rf_addr_b;
    o_alu_op      = w_in_exec ? OPS'(w_alu_op) : '0;
    o_alu_a       = w_in_exec ? r_op_a : '0;
    o_alu_b       = w_in_exec ? r_op_b : '0;
    o_rf_wr_en    = (r_state == ST_WB);
    o_rf_wr_addr  = (r_state == ST_WB) ? r_rf_addr_a : '0;
    o_rf_wr_data  = (r_state == ST_WB) ? r_result : '0;
    o_flag_zero   = r_flag_zero;
    o_flag_sign   = r_flag_sign;
    o_br_valid    = (r_state == ST_BRANCH);
    o_br_taken    = (r_state == ST_BRANCH) &&
                    ((w_branch_cond == BR_SIGN) ? r_flag_sign : r_flag_zero);
    o_halted      = (r_state == ST_HALT);
  end

endmodule : alu_op_sequencer
`default_nettype wire
